// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle MIPS control unit:
// FSM state encoding, internal ALU op classes, opcode/funct and ALU control codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave):
// instruction fields and status in, mux selects and enables out.
interface multicycle_controller_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the controller's alu_op class plus the
// R-type funct field onto the 3-bit ALU function code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised funct codes fall back to add.
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: sequences the shared memory port,
// ALU and datapath muxes, stretching memory states until mem_ready.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter state_t ResetState = FETCH
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master ctrl
);

    state_t  state_reg;
    state_t  state_next;
    alu_op_t alu_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ResetState;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = FETCH;
        alu_op          = ALUOP_ADD;
        ctrl.pc_en      = 1'b0;
        ctrl.i_or_d     = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.ir_write   = 1'b0;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = 2'b00;
        ctrl.pc_src     = 2'b00;
        ctrl.instr_done = 1'b0;
        ctrl.illegal_op = 1'b0;

        case (state_reg)
            FETCH: begin
                // PC + 4 is computed every fetch cycle but only committed on mem_ready.
                ctrl.alu_src_b = 2'b01;
                if (ctrl.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    state_next    = DECODE;
                end else begin
                    state_next    = FETCH;
                end
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
                case (ctrl.opcode)
                    OP_RTYPE:      state_next = EXEC;
                    OP_LW, OP_SW:  state_next = MEMADR;
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_ADDI:       state_next = ADDIEX;
                    OP_J:          state_next = JUMP;
                    default:       ctrl.illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_next     = (ctrl.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.i_or_d = 1'b1;
                state_next  = ctrl.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
                if (ctrl.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                end else begin
                    state_next      = MEMWR;
                end
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                alu_op         = ALUOP_FUNCT;
                state_next     = ALUWB;
            end
            ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                alu_op          = ALUOP_SUB;
                ctrl.pc_src     = 2'b01;
                ctrl.instr_done = 1'b1;
                ctrl.pc_en      = (ctrl.opcode == OP_BNE) ? ~ctrl.zero : ctrl.zero;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_next     = ADDIWB;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src     = 2'b10;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Reset asserted: silence every output immediately, independent of the clock.
        if (!rst) begin
            alu_op          = ALUOP_ADD;
            ctrl.pc_en      = 1'b0;
            ctrl.i_or_d     = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.ir_write   = 1'b0;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.alu_src_a  = 1'b0;
            ctrl.alu_src_b  = 2'b00;
            ctrl.pc_src     = 2'b00;
            ctrl.instr_done = 1'b0;
            ctrl.illegal_op = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (ctrl.funct),
        .alu_control (ctrl.alu_control)
    );

endmodule
